// File: rtl/keyboard_pkg.sv
// ---------------------------------------------------------------------------
// keyboard_pkg
// Shared types and constants for the PS/2 keyboard receive path.
//   ps2_state_t          : receiver FSM states
//   PS2_DATA_BITS        : data bits per PS/2 frame
//   DEFAULT_FILTER_LEN   : default clock-filter length
//   DEFAULT_TIMEOUT_CYCLES : default intra-frame timeout (2 ms at 50 MHz)
// ---------------------------------------------------------------------------
package keyboard_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam int PS2_DATA_BITS          = 8;
   localparam int DEFAULT_FILTER_LEN     = 4;
   localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

   // Odd parity: data plus parity bit must hold an odd number of ones.
   function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                      input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/keyboard_ps2_receiver_if.sv
// ---------------------------------------------------------------------------
// keyboard_ps2_receiver_if
// Bus between the PS/2 receiver (master) and the FIFO / keyboard controller
// side (slave).
//   iFIFO_FULL  : FIFO full flag, into the receiver
//   oWR_EN      : one-cycle FIFO write strobe
//   oWR_DATA    : scancode, held until the next write
//   oPARITY_ERR : one-cycle parity error pulse
//   oFRAME_ERR  : one-cycle framing / timeout error pulse
//   oOVERFLOW   : one-cycle pulse, good frame dropped on full FIFO
//   oBUSY       : receiver is mid-frame
// ---------------------------------------------------------------------------
interface keyboard_ps2_receiver_if;

   logic       iFIFO_FULL;
   logic       oWR_EN;
   logic [7:0] oWR_DATA;
   logic       oPARITY_ERR;
   logic       oFRAME_ERR;
   logic       oOVERFLOW;
   logic       oBUSY;

   modport master (
      input  iFIFO_FULL,
      output oWR_EN, oWR_DATA, oPARITY_ERR, oFRAME_ERR, oOVERFLOW, oBUSY
   );

   modport slave (
      output iFIFO_FULL,
      input  oWR_EN, oWR_DATA, oPARITY_ERR, oFRAME_ERR, oOVERFLOW, oBUSY
   );

endinterface

// File: rtl/keyboard_ps2_filter.sv
// ---------------------------------------------------------------------------
// keyboard_ps2_filter
// Input conditioning for the PS/2 pins.
//   iCLOCK, inRESET : system clock, async active-low reset
//   iPS2_CLK        : raw PS/2 clock pin
//   iPS2_DATA       : raw PS/2 data pin
//   oFE             : one-cycle pulse on a filtered clock 1->0 transition
//   oDATA           : synchronized data pin (unfiltered)
// The clock level only changes after FILTER_LEN consecutive synchronized
// samples disagree with the current filtered level.
// ---------------------------------------------------------------------------
module keyboard_ps2_filter
   import keyboard_pkg::*;
#(
   parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
   input  logic iCLOCK,
   input  logic inRESET,
   input  logic iPS2_CLK,
   input  logic iPS2_DATA,
   output logic oFE,
   output logic oDATA
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          filt;
   logic [CW-1:0] cnt;
   logic          fe_q;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt     <= 1'b1;
         cnt      <= '0;
         fe_q     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], iPS2_CLK};
         dat_sync <= {dat_sync[0], iPS2_DATA};
         fe_q     <= 1'b0;
         if (clk_sync[1] != filt) begin
            if (cnt == CW'(FILTER_LEN - 1)) begin
               filt <= clk_sync[1];
               cnt  <= '0;
               // only the high->low flip produces an edge pulse
               fe_q <= filt;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign oFE   = fe_q;
   assign oDATA = dat_sync[1];

endmodule

// File: rtl/keyboard_ps2_receiver.sv
// ---------------------------------------------------------------------------
// keyboard_ps2_receiver
// Deserializes PS/2 device-to-host frames (start, 8 data LSB-first, odd
// parity, stop) and writes good scancodes into the keyboard sync FIFO.
//   iCLOCK, inRESET : system clock, async active-low reset
//   iPS2_CLK        : raw PS/2 clock pin
//   iPS2_DATA       : raw PS/2 data pin
//   bus (master)    : FIFO write strobe/data, full flag, error pulses, busy
// All strobes are registered and last exactly one cycle.
// ---------------------------------------------------------------------------
module keyboard_ps2_receiver
   import keyboard_pkg::*;
#(
   parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int TO_N           = 17
) (
   input  logic                  iCLOCK,
   input  logic                  inRESET,
   input  logic                  iPS2_CLK,
   input  logic                  iPS2_DATA,
   keyboard_ps2_receiver_if.master bus
);

   localparam int BCW = $clog2(PS2_DATA_BITS);

   logic                     fe;
   logic                     din;
   ps2_state_t               state;
   logic [BCW-1:0]           bit_cnt;
   logic [PS2_DATA_BITS-1:0] shift;
   logic                     par;
   logic [TO_N-1:0]          to_cnt;

   logic                     wr_en_q;
   logic [PS2_DATA_BITS-1:0] wr_data_q;
   logic                     par_err_q;
   logic                     frm_err_q;
   logic                     ovf_q;

   keyboard_ps2_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .iCLOCK    (iCLOCK),
      .inRESET   (inRESET),
      .iPS2_CLK  (iPS2_CLK),
      .iPS2_DATA (iPS2_DATA),
      .oFE       (fe),
      .oDATA     (din)
   );

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         par       <= 1'b0;
         to_cnt    <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_en_q   <= 1'b0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         ovf_q     <= 1'b0;

         if (fe) begin
            // an edge always wins over a coincident timeout
            to_cnt <= '0;
            unique case (state)
               IDLE: begin
                  if (!din) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     frm_err_q <= 1'b1;
                  end
               end
               DATA: begin
                  shift[bit_cnt] <= din;
                  bit_cnt        <= bit_cnt + 1'b1;
                  if (bit_cnt == BCW'(PS2_DATA_BITS - 1))
                     state <= PARITY;
               end
               PARITY: begin
                  par   <= din;
                  state <= STOP;
               end
               STOP: begin
                  if (!din)
                     frm_err_q <= 1'b1;
                  else if (!parity_ok(shift, par))
                     par_err_q <= 1'b1;
                  else if (bus.iFIFO_FULL)
                     ovf_q <= 1'b1;
                  else begin
                     wr_en_q   <= 1'b1;
                     wr_data_q <= shift;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state == IDLE) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_N'(TIMEOUT_CYCLES - 2)) begin
            // the register lags the edge by one cycle, so this is the cycle
            // that sits TIMEOUT_CYCLES-1 cycles after the last edge
            state     <= IDLE;
            frm_err_q <= 1'b1;
            to_cnt    <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   assign bus.oWR_EN      = wr_en_q;
   assign bus.oWR_DATA    = wr_data_q;
   assign bus.oPARITY_ERR = par_err_q;
   assign bus.oFRAME_ERR  = frm_err_q;
   assign bus.oOVERFLOW   = ovf_q;
   assign bus.oBUSY       = (state != IDLE);

endmodule

// File: tb/tb_keyboard_ps2_receiver.sv
// ---------------------------------------------------------------------------
// tb_keyboard_ps2_receiver
// Drives PS/2 frames bit by bit and compares strobe counts and scancodes
// against a frame-level outcome model.
// ---------------------------------------------------------------------------
module tb_keyboard_ps2_receiver;

   localparam int FL   = 4;
   localparam int TO   = 300;
   localparam int TON  = 9;
   localparam int HALF = 20;

   logic iCLOCK  = 1'b0;
   logic inRESET = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_dat = 1'b1;

   keyboard_ps2_receiver_if bus ();

   keyboard_ps2_receiver #(
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TO),
      .TO_N           (TON)
   ) dut (
      .iCLOCK    (iCLOCK),
      .inRESET   (inRESET),
      .iPS2_CLK  (ps2_clk),
      .iPS2_DATA (ps2_dat),
      .bus       (bus)
   );

   always #5 iCLOCK = ~iCLOCK;

   int checks = 0;
   int errors = 0;

   // monitor: event counters, last written byte, multi-cycle pulse detector
   int cyc = 0, n_wr = 0, n_par = 0, n_frm = 0, n_ovf = 0, n_long = 0, t_frm = 0;
   logic p_wr = 0, p_par = 0, p_frm = 0, p_ovf = 0;

   always @(negedge iCLOCK) begin
      cyc++;
      if (inRESET) begin
         if (bus.oWR_EN)      n_wr++;
         if (bus.oPARITY_ERR) n_par++;
         if (bus.oOVERFLOW)   n_ovf++;
         if (bus.oFRAME_ERR) begin n_frm++; t_frm = cyc; end
         if ((bus.oWR_EN && p_wr) || (bus.oPARITY_ERR && p_par) ||
             (bus.oFRAME_ERR && p_frm) || (bus.oOVERFLOW && p_ovf))
            n_long++;
      end
      p_wr  = bus.oWR_EN;
      p_par = bus.oPARITY_ERR;
      p_frm = bus.oFRAME_ERR;
      p_ovf = bus.oOVERFLOW;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] exp_wd = 8'h00;
   int w0, pe0, f0, o0;

   // frame-level reference: 0 write, 1 parity error, 2 frame error, 3 overflow
   function automatic int model(input logic [7:0] d, input logic p,
                                input logic s, input logic full);
      if (!s) return 2;
      if ((($countones(d) + int'(p)) % 2) == 0) return 1;
      if (full) return 3;
      return 0;
   endfunction

   function automatic logic good_par(input logic [7:0] d);
      return ($countones(d) % 2) == 0;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge iCLOCK);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_dat = b;
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(p);
      ps2_bit(s);
      ps2_dat = 1'b1;
      cycles(30);
   endtask

   task automatic snap();
      w0 = n_wr; pe0 = n_par; f0 = n_frm; o0 = n_ovf;
   endtask

   task automatic test_reset();
      bus.iFIFO_FULL = 1'b0;
      cycles(3);
      checks++; if (bus.oWR_EN !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", bus.oWR_EN); end
      checks++; if (bus.oWR_DATA !== 8'h00) begin errors++; $display("FAIL rst_wr_data: got %h want 00", bus.oWR_DATA); end
      checks++; if ({bus.oPARITY_ERR, bus.oFRAME_ERR, bus.oOVERFLOW} !== 3'b000) begin errors++; $display("FAIL rst_errs: got %b want 000", {bus.oPARITY_ERR, bus.oFRAME_ERR, bus.oOVERFLOW}); end
      checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.oBUSY); end
      inRESET = 1'b1;
      cycles(10);
   endtask

   task automatic test_good_frame();
      logic [7:0] d = 8'h1C;
      snap();
      ps2_bit(1'b0);
      ps2_bit(d[0]);
      checks++; if (bus.oBUSY !== 1'b1) begin errors++; $display("FAIL good_busy_mid: got %b want 1", bus.oBUSY); end
      for (int i = 1; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      cycles(30);
      exp_wd = d;
      checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL good_wr: got %0d want 1", n_wr - w0); end
      checks++; if (bus.oWR_DATA !== exp_wd) begin errors++; $display("FAIL good_data: got %h want %h", bus.oWR_DATA, exp_wd); end
      checks++; if ((n_par - pe0) + (n_frm - f0) + (n_ovf - o0) !== 0) begin errors++; $display("FAIL good_errs: got %0d want 0", (n_par - pe0) + (n_frm - f0) + (n_ovf - o0)); end
      checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL good_busy_end: got %b want 0", bus.oBUSY); end
   endtask

   task automatic test_bad_parity();
      snap();
      send_frame(8'h1C, 1'b1, 1'b1);
      checks++; if (n_par - pe0 !== 1) begin errors++; $display("FAIL par_err: got %0d want 1", n_par - pe0); end
      checks++; if (n_wr - w0 !== 0) begin errors++; $display("FAIL par_wr: got %0d want 0", n_wr - w0); end
      checks++; if (bus.oWR_DATA !== exp_wd) begin errors++; $display("FAIL par_data_held: got %h want %h", bus.oWR_DATA, exp_wd); end
      snap();
      send_frame(8'h33, 1'b1, 1'b0);
      checks++; if (n_frm - f0 !== 1) begin errors++; $display("FAIL stop_frm: got %0d want 1", n_frm - f0); end
      checks++; if ((n_wr - w0) + (n_par - pe0) + (n_ovf - o0) !== 0) begin errors++; $display("FAIL stop_others: got %0d want 0", (n_wr - w0) + (n_par - pe0) + (n_ovf - o0)); end
   endtask

   task automatic test_overflow();
      snap();
      bus.iFIFO_FULL = 1'b1;
      send_frame(8'hF0, 1'b1, 1'b1);
      checks++; if (n_ovf - o0 !== 1) begin errors++; $display("FAIL ovf_pulse: got %0d want 1", n_ovf - o0); end
      checks++; if (n_wr - w0 !== 0) begin errors++; $display("FAIL ovf_wr: got %0d want 0", n_wr - w0); end
      checks++; if (bus.oWR_DATA !== exp_wd) begin errors++; $display("FAIL ovf_data_held: got %h want %h", bus.oWR_DATA, exp_wd); end
      snap();
      bus.iFIFO_FULL = 1'b0;
      send_frame(8'hF0, 1'b1, 1'b1);
      exp_wd = 8'hF0;
      checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL ovf_retry_wr: got %0d want 1", n_wr - w0); end
      checks++; if (bus.oWR_DATA !== exp_wd) begin errors++; $display("FAIL ovf_retry_data: got %h want %h", bus.oWR_DATA, exp_wd); end
   endtask

   task automatic test_timeout();
      logic [7:0] d = 8'hA5;
      int c0, dt;
      snap();
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(d[i]);
      ps2_dat = d[3];
      cycles(HALF);
      ps2_clk = 1'b0;
      c0 = cyc;
      cycles(HALF);
      ps2_clk = 1'b1;
      for (int k = 0; k < TO + 100; k++) begin
         if (n_frm != f0) break;
         cycles(1);
      end
      dt = t_frm - c0;
      checks++; if (n_frm - f0 !== 1) begin errors++; $display("FAIL to_pulse: got %0d want 1", n_frm - f0); end
      checks++; if (dt < TO || dt > TO + FL + 6) begin errors++; $display("FAIL to_delay: got %0d want %0d..%0d", dt, TO, TO + FL + 6); end
      cycles(2);
      checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", bus.oBUSY); end
      checks++; if (n_wr - w0 !== 0) begin errors++; $display("FAIL to_wr: got %0d want 0", n_wr - w0); end
      snap();
      send_frame(8'h5A, 1'b1, 1'b1);
      exp_wd = 8'h5A;
      checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL to_next_wr: got %0d want 1", n_wr - w0); end
      checks++; if (bus.oWR_DATA !== exp_wd) begin errors++; $display("FAIL to_next_data: got %h want %h", bus.oWR_DATA, exp_wd); end
   endtask

   task automatic test_glitch();
      snap();
      ps2_dat = 1'b1;
      ps2_clk = 1'b0;
      cycles(FL - 1);
      ps2_clk = 1'b1;
      cycles(20);
      checks++; if ((n_frm - f0) + (n_wr - w0) !== 0) begin errors++; $display("FAIL glitch_short: got %0d events want 0", (n_frm - f0) + (n_wr - w0)); end
      checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", bus.oBUSY); end
      ps2_clk = 1'b0;
      cycles(FL + 2);
      ps2_clk = 1'b1;
      cycles(20);
      checks++; if (n_frm - f0 !== 1) begin errors++; $display("FAIL glitch_start: got %0d want 1", n_frm - f0); end
      checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL glitch_start_busy: got %b want 0", bus.oBUSY); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d = 8'h12;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(d[i]);
      cycles(5);
      #2;
      inRESET = 1'b0;
      #1;
      checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", bus.oBUSY); end
      checks++; if (bus.oWR_DATA !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", bus.oWR_DATA); end
      checks++; if ({bus.oWR_EN, bus.oPARITY_ERR, bus.oFRAME_ERR, bus.oOVERFLOW} !== 4'b0000) begin errors++; $display("FAIL rmid_strobes: got %b want 0000", {bus.oWR_EN, bus.oPARITY_ERR, bus.oFRAME_ERR, bus.oOVERFLOW}); end
      exp_wd = 8'h00;
      cycles(5);
      inRESET = 1'b1;
      cycles(10);
      snap();
      send_frame(d, 1'b1, 1'b1);
      exp_wd = d;
      checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL rmid_next_wr: got %0d want 1", n_wr - w0); end
      checks++; if (bus.oWR_DATA !== exp_wd) begin errors++; $display("FAIL rmid_next_data: got %h want %h", bus.oWR_DATA, exp_wd); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      snap();
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(a[i]);
      ps2_bit(good_par(a));
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(good_par(b));
      ps2_bit(1'b1);
      cycles(30);
      exp_wd = b;
      checks++; if (n_wr - w0 !== 2) begin errors++; $display("FAIL b2b_wr: got %0d want 2", n_wr - w0); end
      checks++; if (bus.oWR_DATA !== exp_wd) begin errors++; $display("FAIL b2b_data: got %h want %h", bus.oWR_DATA, exp_wd); end
      checks++; if ((n_par - pe0) + (n_frm - f0) !== 0) begin errors++; $display("FAIL b2b_errs: got %0d want 0", (n_par - pe0) + (n_frm - f0)); end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic p, s, full;
      int kind, outc;
      for (int n = 0; n < 16; n++) begin
         d    = 8'($urandom);
         kind = int'($urandom_range(0, 3));
         p    = good_par(d);
         s    = 1'b1;
         full = 1'b0;
         if (kind == 1) p = ~p;
         if (kind == 2) begin s = 1'b0; p = 1'($urandom); end
         if (kind == 3) full = 1'b1;
         outc = model(d, p, s, full);
         if (outc == 0) exp_wd = d;
         bus.iFIFO_FULL = full;
         snap();
         send_frame(d, p, s);
         bus.iFIFO_FULL = 1'b0;
         checks++;
         if ((n_wr - w0)   !== ((outc == 0) ? 1 : 0) ||
             (n_par - pe0) !== ((outc == 1) ? 1 : 0) ||
             (n_frm - f0)  !== ((outc == 2) ? 1 : 0) ||
             (n_ovf - o0)  !== ((outc == 3) ? 1 : 0)) begin
            errors++;
            $display("FAIL rand_outcome[%0d]: d=%h p=%b s=%b full=%b got wr/par/frm/ovf=%0d%0d%0d%0d want kind %0d",
                     n, d, p, s, full, n_wr - w0, n_par - pe0, n_frm - f0, n_ovf - o0, outc);
         end
         checks++; if (bus.oWR_DATA !== exp_wd) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", n, bus.oWR_DATA, exp_wd); end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_parity();
      test_overflow();
      test_timeout();
      test_glitch();
      test_back_to_back();
      test_random();
      test_reset_mid();
      checks++; if (n_long !== 0) begin errors++; $display("FAIL single_cycle: got %0d long pulses want 0", n_long); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keyboard_ps2_receiver.md
Name: keyboard_ps2_receiver

Overview:
- Upstream producer for the keyboard sync FIFO.
- Deserializes PS/2 device-to-host frames into 8-bit scancodes: 1 start, 8 data LSB-first, odd parity, 1 stop.
- Writes each good scancode into the FIFO with a single-cycle write strobe, gated by the FIFO full flag.
- Reports parity, framing/timeout and overflow errors as one-cycle pulses to the keyboard controller.

Parameters:
- FILTER_LEN, 4: number of consecutive equal synchronized PS/2 clock samples needed to change the filtered clock level (≥2).
- TIMEOUT_CYCLES, 100000: iCLOCK cycles allowed between PS/2 falling edges inside a frame (2 ms at 50 MHz).
- TO_N, 17: width of the timeout counter; must satisfy 2^TO_N > TIMEOUT_CYCLES.

Ports:
- iCLOCK  in  1  system clock
- inRESET  in  1  asynchronous active-low reset
- iPS2_CLK  in  1  raw PS/2 clock pin, asynchronous
- iPS2_DATA  in  1  raw PS/2 data pin, asynchronous
- iFIFO_FULL  in  1  FIFO full flag (the FIFO's oWR_FULL)
- oWR_EN  out  1  one-cycle FIFO write strobe
- oWR_DATA  out  8  scancode; valid while oWR_EN=1 and held until the next write
- oPARITY_ERR  out  1  one-cycle pulse
- oFRAME_ERR  out  1  one-cycle pulse: bad start, bad stop or timeout
- oOVERFLOW  out  1  one-cycle pulse: good frame dropped because the FIFO was full
- oBUSY  out  1  high while the receiver is in any state other than IDLE

Behaviour:
- Reset: one clock iCLOCK; reset inRESET is asynchronous, active-low. Reset (or inRESET low mid-frame) forces state IDLE and clears the bit counter, shift register, timeout counter and filter. All outputs go to 0, oWR_DATA=8'h00. Filter state resets to 1 (bus idle high).
- Input conditioning:
  - Both pins pass through a 2-FF synchronizer.
  - Filtered clock toggles only after FILTER_LEN consecutive equal samples of the opposite level.
  - A falling edge (fe) is a one-cycle pulse when filtered clock goes 1→0.
  - Data is the synchronized iPS2_DATA value sampled in the fe cycle. No filtering on data.
- FSM states IDLE, DATA, PARITY, STOP. All transitions occur only on fe, except timeout.
  - IDLE: fe with data=0 → DATA, bit count=0. fe with data=1 → oFRAME_ERR, stay in IDLE.
  - DATA: shift data in LSB-first (bit i lands in shift[i]), count+1. On the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP. Parity is OK when the 8 data bits plus the parity bit contain an odd number of ones.
  - STOP: evaluate in this priority order, then → IDLE in all cases:
    1. Stop bit=0 → oFRAME_ERR.
    2. Otherwise, parity bad → oPARITY_ERR.
    3. Otherwise, iFIFO_FULL=1 → oOVERFLOW; data dropped, oWR_DATA unchanged.
    4. Otherwise → oWR_EN=1, oWR_DATA=shift.
- Exactly one of the four STOP outcomes per frame.
- Latency: oWR_EN and the error pulses are registered and assert in the cycle after the stop-bit fe cycle.
- iFIFO_FULL is sampled in the stop-bit fe cycle.
- Timeout:
  - Counter clears on every fe and whenever the state is IDLE; otherwise it increments.
  - When it reaches TIMEOUT_CYCLES-1 outside IDLE: → IDLE, oFRAME_ERR pulse, partial frame discarded.
  - If fe and timeout coincide, fe wins (counter clears, normal transition).
- No output ever asserts for more than one cycle per event. Nothing is written on any error path.
- Back-to-back frames: a start bit arriving on the fe right after STOP→IDLE is accepted normally.

Decomposition:
- Shared package keyboard_pkg:
  - state enum (IDLE, DATA, PARITY, STOP)
  - constant PS2_DATA_BITS=8
  - default FILTER_LEN and TIMEOUT_CYCLES
- Sub-module keyboard_ps2_filter: 2-FF sync of clock and data, level filter, fe pulse output. Instantiated once.

Test Plan:
- Good frame: 0x1C with parity=0 (three ones) and stop=1 → one oWR_EN pulse with oWR_DATA=8'h1C one cycle after the stop fe; no error pulses; oBUSY back to 0.
- Bad parity: 0x1C with parity=1 → oPARITY_ERR single pulse, no oWR_EN, oWR_DATA keeps its previous value. Stop=0 on a good frame → oFRAME_ERR only.
- Overflow: iFIFO_FULL=1, good frame 0xF0 with parity=1 → oOVERFLOW pulse, no oWR_EN. Same frame repeated with iFIFO_FULL=0 → oWR_EN with 8'hF0.
- Timeout: start bit plus 4 data bits, then clock held high TIMEOUT_CYCLES → oFRAME_ERR at exactly TIMEOUT_CYCLES-1 cycles after the last fe; state IDLE. Next good frame 0x5A (parity=1) is received correctly.
- Glitch: PS/2 clock low pulse of FILTER_LEN-1 cycles while IDLE → no fe, no state change. A pulse of FILTER_LEN+2 cycles with data=1 → oFRAME_ERR (bad start).
- Reset mid-frame: inRESET low after 5 data bits → all outputs 0 asynchronously. After release, a full frame 0x12 (parity=1) is written correctly.
